// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side capture, forwarding and EX-side outputs of the ID/EX register.
interface id_ex_stage_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CTRL_BITS  = 4,
   parameter int REG_BITS   = 5
);
   logic                  stall, flush, id_valid, id_funct7b5;
   logic [2:0]            id_op, id_funct3;
   logic [REG_BITS-1:0]   id_rs1, id_rs2, id_rd, mem_fwd_rd, wb_fwd_rd, ex_rd;
   logic [DATA_WIDTH-1:0] id_rs1_data, id_rs2_data, id_imm, mem_fwd_data, wb_fwd_data;
   logic                  mem_fwd_we, wb_fwd_we;
   logic                  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
   logic                  ex_br_on_zero, ex_illegal;
   logic [CTRL_BITS-1:0]  alu_ctrl;
   logic [DATA_WIDTH-1:0] alu_a, alu_b, ex_store_data;
   modport master (
      output stall, flush, id_valid, id_op, id_funct3, id_funct7b5, id_rs1, id_rs2, id_rd,
             id_rs1_data, id_rs2_data, id_imm, mem_fwd_we, mem_fwd_rd, mem_fwd_data,
             wb_fwd_we, wb_fwd_rd, wb_fwd_data,
      input  ex_valid, alu_ctrl, alu_a, alu_b, ex_store_data, ex_rd, ex_reg_write,
             ex_mem_read, ex_mem_write, ex_branch, ex_br_on_zero, ex_illegal
   );
   modport slave (
      input  stall, flush, id_valid, id_op, id_funct3, id_funct7b5, id_rs1, id_rs2, id_rd,
             id_rs1_data, id_rs2_data, id_imm, mem_fwd_we, mem_fwd_rd, mem_fwd_data,
             wb_fwd_we, wb_fwd_rd, wb_fwd_data,
      output ex_valid, alu_ctrl, alu_a, alu_b, ex_store_data, ex_rd, ex_reg_write,
             ex_mem_read, ex_mem_write, ex_branch, ex_br_on_zero, ex_illegal
   );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding, ALU control decode, stall and flush.
module id_ex_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int CTRL_BITS  = 4,
   parameter int REG_BITS   = 5
) (
   input logic         clk,
   input logic         rst,
   id_ex_stage_if.slave bus
);
   logic [DATA_WIDTH-1:0] fa, fb;
   logic [CTRL_BITS-1:0]  ctrl;
   logic                  ill, rw, mr, mw, br, boz, use_imm;
   always_comb begin
      fa = (bus.mem_fwd_we && bus.mem_fwd_rd == bus.id_rs1 && bus.id_rs1 != '0) ? bus.mem_fwd_data :
           (bus.wb_fwd_we && bus.wb_fwd_rd == bus.id_rs1 && bus.id_rs1 != '0) ? bus.wb_fwd_data : bus.id_rs1_data;
      fb = (bus.mem_fwd_we && bus.mem_fwd_rd == bus.id_rs2 && bus.id_rs2 != '0) ? bus.mem_fwd_data :
           (bus.wb_fwd_we && bus.wb_fwd_rd == bus.id_rs2 && bus.id_rs2 != '0) ? bus.wb_fwd_data : bus.id_rs2_data;
      use_imm = bus.id_op == 3'b001 || bus.id_op == 3'b010 || bus.id_op == 3'b011;
      ctrl = '1;
      ill = 1'b0;
      rw = 1'b0;
      mr = 1'b0;
      mw = 1'b0;
      br = 1'b0;
      boz = 1'b0;
      case (bus.id_op)
         3'b000, 3'b001: begin
            rw = 1'b1;
            case (bus.id_funct3)
               3'b000:  ctrl = (bus.id_op == 3'b000 && bus.id_funct7b5) ? 4'b0110 : 4'b0010;
               3'b111:  ctrl = 4'b0000;
               3'b110:  ctrl = 4'b0001;
               3'b010:  ctrl = 4'b0111;
               default: ill = 1'b1;
            endcase
         end
         3'b010: begin
            ctrl = 4'b0010;
            rw = 1'b1;
            mr = 1'b1;
         end
         3'b011: begin
            ctrl = 4'b0010;
            mw = 1'b1;
         end
         3'b100: begin
            br = 1'b1;
            case (bus.id_funct3)
               3'b000: begin
                  ctrl = 4'b0110;
                  boz = 1'b1;
               end
               3'b001:  ctrl = 4'b0110;
               3'b100:  ctrl = 4'b0111;
               3'b101:  ctrl = 4'b0101;
               default: ill = 1'b1;
            endcase
         end
         default: ill = 1'b1;
      endcase
      // illegal encodings and bubbles both carry no stage controls
      if (ill || !bus.id_valid) begin
         ctrl = '1;
         {rw, mr, mw, br, boz} = '0;
      end
      if (!bus.id_valid) ill = 1'b0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write} <= '0;
         {bus.ex_branch, bus.ex_br_on_zero, bus.ex_illegal} <= '0;
         bus.alu_ctrl <= '1;
         bus.alu_a <= '0;
         bus.alu_b <= '0;
         bus.ex_store_data <= '0;
         bus.ex_rd <= '0;
      end else if (bus.flush) begin
         {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write} <= '0;
         {bus.ex_branch, bus.ex_br_on_zero, bus.ex_illegal} <= '0;
         bus.alu_ctrl <= '1;
      end else if (!bus.stall) begin
         bus.ex_valid <= bus.id_valid;
         bus.ex_reg_write <= rw;
         bus.ex_mem_read <= mr;
         bus.ex_mem_write <= mw;
         bus.ex_branch <= br;
         bus.ex_br_on_zero <= boz;
         bus.ex_illegal <= ill;
         bus.alu_ctrl <= ctrl;
         bus.alu_a <= fa;
         bus.alu_b <= use_imm ? bus.id_imm : fb;
         bus.ex_store_data <= fb;
         bus.ex_rd <= bus.id_rd;
      end
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven check of capture, forwarding and decode, plus stall/flush/reset sequences.
module tb_id_ex_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   id_ex_stage_if bus ();
   id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   typedef struct {
      logic        iv;
      logic [2:0]  op, f3;
      logic        f7;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] d1, d2, imm;
      logic        mwe;
      logic [4:0]  mrd;
      logic [31:0] mdat;
      logic        wwe;
      logic [4:0]  wrd;
      logic [31:0] wdat;
      logic        e_v;
      logic [3:0]  e_ctrl;
      logic [31:0] e_a, e_b, e_sd;
      logic        e_rw, e_mr, e_mw, e_br, e_boz, e_ill;
   } vec_t;
   vec_t tv[15];
   vec_t st;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask
   task automatic drive(input vec_t t);
      bus.id_valid = t.iv;
      bus.id_op = t.op;
      bus.id_funct3 = t.f3;
      bus.id_funct7b5 = t.f7;
      bus.id_rs1 = t.rs1;
      bus.id_rs2 = t.rs2;
      bus.id_rd = t.rd;
      bus.id_rs1_data = t.d1;
      bus.id_rs2_data = t.d2;
      bus.id_imm = t.imm;
      bus.mem_fwd_we = t.mwe;
      bus.mem_fwd_rd = t.mrd;
      bus.mem_fwd_data = t.mdat;
      bus.wb_fwd_we = t.wwe;
      bus.wb_fwd_rd = t.wrd;
      bus.wb_fwd_data = t.wdat;
   endtask
   task automatic check_vec(input string n, input vec_t t);
      chk({n, " valid"}, 32'(bus.ex_valid), 32'(t.e_v));
      chk({n, " ctrl"}, 32'(bus.alu_ctrl), 32'(t.e_ctrl));
      chk({n, " alu_a"}, bus.alu_a, t.e_a);
      chk({n, " alu_b"}, bus.alu_b, t.e_b);
      chk({n, " store_data"}, bus.ex_store_data, t.e_sd);
      chk({n, " rd"}, 32'(bus.ex_rd), 32'(t.rd));
      chk({n, " reg_write"}, 32'(bus.ex_reg_write), 32'(t.e_rw));
      chk({n, " mem_read"}, 32'(bus.ex_mem_read), 32'(t.e_mr));
      chk({n, " mem_write"}, 32'(bus.ex_mem_write), 32'(t.e_mw));
      chk({n, " branch"}, 32'(bus.ex_branch), 32'(t.e_br));
      chk({n, " br_on_zero"}, 32'(bus.ex_br_on_zero), 32'(t.e_boz));
      chk({n, " illegal"}, 32'(bus.ex_illegal), 32'(t.e_ill));
   endtask
   task automatic check_reset(input string n);
      chk({n, " valid"}, 32'(bus.ex_valid), 0);
      chk({n, " ctrl"}, 32'(bus.alu_ctrl), 32'hf);
      chk({n, " alu_a"}, bus.alu_a, 0);
      chk({n, " alu_b"}, bus.alu_b, 0);
      chk({n, " store_data"}, bus.ex_store_data, 0);
      chk({n, " rd"}, 32'(bus.ex_rd), 0);
      chk({n, " ctl_bits"}, 32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                                 bus.ex_branch, bus.ex_br_on_zero, bus.ex_illegal}), 0);
   endtask
   initial begin
      //        iv op     f3     f7 rs1 rs2 rd  d1     d2      imm           mwe mrd mdat     wwe wrd wdat     v ctrl     a        b             sd      rw mr mw br bz il
      tv[0]  = '{1, 3'b000, 3'b000, 1, 1, 2, 3, 75, 25, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0110, 75, 25, 25, 1, 0, 0, 0, 0, 0};
      tv[1]  = '{1, 3'b001, 3'b000, 0, 3, 4, 7, 1, 2, 32'hffffffff, 1, 3, 32'hdead, 1, 3, 32'hbeef,
                 1, 4'b0010, 32'hdead, 32'hffffffff, 2, 1, 0, 0, 0, 0, 0};
      tv[2]  = '{1, 3'b001, 3'b000, 0, 0, 0, 8, 0, 0, 7, 1, 0, 5, 1, 0, 9, 1, 4'b0010, 0, 7, 0, 1, 0, 0, 0, 0, 0};
      tv[3]  = '{1, 3'b000, 3'b000, 0, 1, 6, 9, 10, 20, 0, 0, 0, 0, 1, 6, 99, 1, 4'b0010, 10, 99, 99, 1, 0, 0, 0, 0, 0};
      tv[4]  = '{1, 3'b000, 3'b111, 0, 2, 6, 10, 32'hf0f0, 32'h0ff0, 0, 1, 6, 44, 1, 6, 55,
                 1, 4'b0000, 32'hf0f0, 44, 44, 1, 0, 0, 0, 0, 0};
      tv[5]  = '{1, 3'b100, 3'b101, 0, 5, 3, 0, 5, 3, 16, 0, 0, 0, 0, 0, 0, 1, 4'b0101, 5, 3, 3, 0, 0, 0, 1, 0, 0};
      tv[6]  = '{1, 3'b100, 3'b000, 0, 5, 3, 0, 5, 3, 16, 0, 0, 0, 0, 0, 0, 1, 4'b0110, 5, 3, 3, 0, 0, 0, 1, 1, 0};
      tv[7]  = '{1, 3'b100, 3'b100, 1, 5, 3, 0, 5, 3, 16, 0, 0, 0, 0, 0, 0, 1, 4'b0111, 5, 3, 3, 0, 0, 0, 1, 0, 0};
      tv[8]  = '{1, 3'b010, 3'b010, 0, 4, 0, 11, 32'h100, 0, 8, 0, 0, 0, 0, 0, 0, 1, 4'b0010, 32'h100, 8, 0, 1, 1, 0, 0, 0, 0};
      tv[9]  = '{1, 3'b000, 3'b110, 1, 1, 2, 12, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0001, 1, 2, 2, 1, 0, 0, 0, 0, 0};
      tv[10] = '{1, 3'b001, 3'b010, 1, 1, 2, 13, 4, 6, 9, 0, 0, 0, 0, 0, 0, 1, 4'b0111, 4, 9, 6, 1, 0, 0, 0, 0, 0};
      tv[11] = '{1, 3'b111, 3'b000, 0, 1, 2, 14, 3, 4, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1111, 3, 4, 4, 0, 0, 0, 0, 0, 1};
      tv[12] = '{1, 3'b000, 3'b001, 0, 1, 2, 15, 3, 4, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1111, 3, 4, 4, 0, 0, 0, 0, 0, 1};
      tv[13] = '{0, 3'b010, 3'b010, 0, 1, 2, 16, 11, 22, 5, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 11, 5, 22, 0, 0, 0, 0, 0, 0};
      tv[14] = '{1, 3'b100, 3'b011, 0, 1, 2, 17, 3, 4, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1111, 3, 4, 4, 0, 0, 0, 0, 0, 1};
      st     = '{1, 3'b011, 3'b010, 0, 8, 9, 0, 32'h200, 32'hcafe, 4, 0, 0, 0, 0, 0, 0,
                 1, 4'b0010, 32'h200, 4, 32'hcafe, 0, 0, 1, 0, 0, 0};
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      drive(tv[0]);
      repeat (2) @(posedge clk);
      #1 check_reset("reset");
      rst = 1'b0;
      foreach (tv[i]) begin
         drive(tv[i]);
         @(posedge clk);
         #1 check_vec($sformatf("vec%0d", i), tv[i]);
      end
      drive(st);
      @(posedge clk);
      #1 check_vec("store", st);
      bus.stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(tv[k]);
         @(posedge clk);
         #1 check_vec($sformatf("stall%0d", k), st);
      end
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      chk("flush valid", 32'(bus.ex_valid), 0);
      chk("flush mem_write", 32'(bus.ex_mem_write), 0);
      chk("flush ctrl", 32'(bus.alu_ctrl), 32'hf);
      chk("flush alu_a hold", bus.alu_a, 32'h200);
      chk("flush store_data hold", bus.ex_store_data, 32'hcafe);
      bus.flush = 1'b0;
      bus.stall = 1'b0;
      drive(tv[0]);
      @(posedge clk);
      #1 check_vec("resume", tv[0]);
      drive(tv[11]);
      @(posedge clk);
      #1 check_vec("illegal", tv[11]);
      #2 rst = 1'b1;
      #1 check_reset("async_reset");
      bus.stall = 1'b1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1 check_reset("reset_over_stall_flush");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU.
- Each cycle it captures one decoded instruction from ID and selects the ALU operands, applying EX/MEM and MEM/WB forwarding.
- It translates opcode class, funct3 and funct7[5] into the 4-bit ALU control code, and registers the memory, writeback and branch control for later stages.
- Supports stall (hold) and flush (bubble insertion).

Parameters:
- DATA_WIDTH, 32, operand/result width
- CTRL_BITS, 4, ALU control width
- REG_BITS, 5, register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold all outputs this cycle
- flush  in  1  replace captured instruction with bubble; priority over stall
- id_valid  in  1  ID slot holds a real instruction
- id_op  in  3  class: 000 R-ALU, 001 I-ALU, 010 load, 011 store, 100 branch, others illegal
- id_funct3  in  3  RISC-V funct3
- id_funct7b5  in  1  instruction bit 30
- id_rs1, id_rs2, id_rd  in  REG_BITS  register indices
- id_rs1_data, id_rs2_data  in  DATA_WIDTH  register file read data
- id_imm  in  DATA_WIDTH  sign-extended immediate
- mem_fwd_we  in  1  EX/MEM instruction writes a register
- mem_fwd_rd  in  REG_BITS  its destination
- mem_fwd_data  in  DATA_WIDTH  its result
- wb_fwd_we, wb_fwd_rd, wb_fwd_data  in  1/REG_BITS/DATA_WIDTH  same, for MEM/WB
- ex_valid  out  1  registered instruction valid
- alu_ctrl  out  CTRL_BITS  ALU operation code
- alu_a, alu_b  out  DATA_WIDTH  ALU operands
- ex_store_data  out  DATA_WIDTH  forwarded rs2 value for stores
- ex_rd  out  REG_BITS  destination index
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  out  1  stage controls
- ex_br_on_zero  out  1  branch taken when ALU zero=1 (else taken when zero=0)
- ex_illegal  out  1  undecodable instruction captured

Behaviour:
- Reset (async, rst=1): all outputs 0 except alu_ctrl=4'b1111. Reset mid-stall or mid-flush overrides both.
- Latency: exactly 1 cycle, ID inputs to registered outputs. No combinational path from inputs to outputs.
- Update priority at each edge: rst > flush > stall > normal capture.
  - flush=1: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal ← 0; alu_ctrl ← 1111; data outputs hold.
  - stall=1 (flush=0): every output holds; forwarding is not re-sampled.
  - Normal: capture from ID.
- Bubble (id_valid=0, normal capture): same as flush, except data registers load as normal.
- Forwarding, applied per source (rs1, rs2) at capture:
  - If mem_fwd_we && mem_fwd_rd==rs && rs!=0 → mem_fwd_data.
  - Else if wb_fwd_we && wb_fwd_rd==rs && rs!=0 → wb_fwd_data.
  - Else register file data. EX/MEM wins when both match.
  - Index 0 is never forwarded.
- alu_a = forwarded rs1.
- alu_b = forwarded rs2 for R-ALU and branch; id_imm for I-ALU, load and store.
- ex_store_data = forwarded rs2 (all classes).
- ALU decode (codes: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 0101 sge):
  - R-ALU: f3=000 → add if f7b5=0, sub if 1; 111 and; 110 or; 010 slt.
  - I-ALU: 000 add; 111 and; 110 or; 010 slt. f7b5 ignored.
  - Load, store: add.
  - Branch: 000 (beq) sub, br_on_zero=1; 001 (bne) sub, br_on_zero=0; 100 (blt) slt, br_on_zero=0; 101 (bge) sge, br_on_zero=0.
  - Any other combination → alu_ctrl=1111, ex_illegal=1, all other controls 0, ex_valid=1.
- Control outputs:
  - ex_reg_write=1 for R-ALU, I-ALU, load.
  - ex_mem_read=1 for load; ex_mem_write=1 for store; ex_branch=1 for branch.
  - ex_br_on_zero=0 for non-branch.
- Simultaneous flush and stall: flush wins.
- After a stall is released, capture resumes on the next edge with current inputs.

Test Plan:
- Reset, then R-ALU f3=000 f7b5=1, rs1_data=75, rs2_data=25 → after 1 edge: alu_ctrl=0110, alu_a=75, alu_b=25, ex_reg_write=1, ex_valid=1.
- I-ALU addi rs1=3 with mem_fwd_we=1, mem_fwd_rd=3, mem_fwd_data=0xDEAD, wb_fwd also matching rs1 with 0xBEEF, imm=-1 → alu_a=0xDEAD, alu_b=0xFFFFFFFF, alu_ctrl=0010.
- Forward attempt to x0 (rs1=0, mem_fwd_rd=0, data=5, rs1_data=0) → alu_a=0.
- Branch f3=101, rs1=5, rs2=3 → alu_ctrl=0101, ex_branch=1, ex_br_on_zero=0; f3=000 → alu_ctrl=0110, ex_br_on_zero=1.
- Store captured, then stall=1 for 3 cycles while ID inputs change → outputs unchanged; assert stall and flush together → ex_valid=0, ex_mem_write=0, alu_ctrl=1111.
- id_op=111 → ex_illegal=1, alu_ctrl=1111, ex_reg_write=0; assert rst asynchronously mid-cycle → all outputs 0 (alu_ctrl=1111) immediately, before the next edge.
